// File: rtl/c_samq_pop_sched_pkg.sv
// c_samq_pop_sched_pkg: shared FSM encodings and helper functions for the pop scheduler
package c_samq_pop_sched_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} fsm_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/c_rr_select.sv
// c_rr_select: grant the first requester at or after the one-hot priority position, cyclically
module c_rr_select #(
  parameter int n = 4
) (
  input  logic [0:n-1] req,
  input  logic [0:n-1] prio,
  output logic [0:n-1] gnt
);
  logic hit;
  // scan from the priority position forward, wrapping past the last index
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int s = 0; s < n; s++)
      for (int k = 0; k < n; k++)
        if (prio[s] && !hit && req[(s + k) % n]) begin
          gnt[(s + k) % n] = 1'b1;
          hit = 1'b1;
        end
  end
endmodule

// File: rtl/c_samq_pop_sched.sv
// c_samq_pop_sched: round-robin burst pop scheduler for a statically allocated multi-queue
module c_samq_pop_sched
  import c_samq_pop_sched_pkg::*;
#(
  parameter int num_queues = 4,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic [0:num_queues-1] empty_qu,
  input  logic [0:num_queues-1] almost_empty_qu,
  input  logic                  ready,
  output logic                  pop_valid,
  output logic [0:num_queues-1] pop_sel_qu,
  output logic                  pop_last
);
  localparam int cw = clog2(max_burst + 1);
  localparam logic [cw-1:0] mb = cw'(max_burst);
  localparam logic [0:num_queues-1] prio_rst = {1'b1, {(num_queues - 1){1'b0}}};
  fsm_t state, state_nxt;
  logic [0:num_queues-1] cur_qu, cur_nxt, prio_qu, prio_nxt, gnt, sel;
  logic [cw-1:0] cnt, cnt_nxt, cnt_inc;
  logic go, vld, last, cur_empty;
  assign go = active & ready & ~reset;
  assign cnt_inc = cnt + cw'(1);
  assign cur_empty = |(cur_qu & empty_qu);
  c_rr_select #(.n(num_queues)) u_rr (
    .req (~empty_qu),
    .prio(prio_qu),
    .gnt (gnt)
  );
  assign pop_valid = vld;
  assign pop_sel_qu = vld ? sel : '0;
  assign pop_last = vld & last;
  // next state and pop decision: idle pops start bursts from the rr winner, bursts stick to cur_qu
  always_comb begin
    state_nxt = state;
    cur_nxt = cur_qu;
    cnt_nxt = cnt;
    prio_nxt = prio_qu;
    vld = 1'b0;
    sel = '0;
    last = 1'b0;
    if (state == IDLE) begin
      vld = go & |gnt;
      sel = gnt;
      last = (max_burst == 1) | |(gnt & almost_empty_qu);
      if (vld) begin
        prio_nxt = {gnt[num_queues-1], gnt[0:num_queues-2]};
        if (!last) begin
          state_nxt = BURST;
          cur_nxt = gnt;
          cnt_nxt = cw'(1);
        end
      end
    end else begin
      vld = go & ~cur_empty;
      sel = cur_qu;
      last = (cnt_inc == mb) | |(cur_qu & almost_empty_qu);
      if (cur_empty) state_nxt = IDLE;
      else if (vld) begin
        cnt_nxt = cnt_inc;
        if (last) state_nxt = IDLE;
      end
    end
  end
  // state register, frozen while active is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur_qu <= '0;
      cnt <= '0;
      prio_qu <= prio_rst;
    end else if (active) begin
      state <= state_nxt;
      cur_qu <= cur_nxt;
      cnt <= cnt_nxt;
      prio_qu <= prio_nxt;
    end
  end
endmodule

// File: tb/tb_c_samq_pop_sched.sv
// tb_c_samq_pop_sched: randomized and directed check of the pop scheduler against a queue-level model
module tb_c_samq_pop_sched;
  localparam int NQ = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic active = 1'b0;
  logic ready = 1'b0;
  logic [0:NQ-1] empty_qu = '1;
  logic [0:NQ-1] almost_empty_qu = '0;
  logic va, la, vb, lb;
  logic [0:NQ-1] sa, sb;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cnt_q[NQ];
  int mb[2] = '{4, 1};
  bit busy[2], nbusy[2];
  int cur[2], ncur[2], npop[2], nnpop[2], pr[2], npr[2];
  logic [0:NQ-1] sel_q[$], bsel_q[$];
  bit v_q[$], l_q[$], bl_q[$];

  always #5 clk = ~clk;

  c_samq_pop_sched #(.num_queues(NQ), .max_burst(4)) dut_a (
    .clk(clk), .reset(reset), .active(active), .empty_qu(empty_qu),
    .almost_empty_qu(almost_empty_qu), .ready(ready),
    .pop_valid(va), .pop_sel_qu(sa), .pop_last(la)
  );

  c_samq_pop_sched #(.num_queues(NQ), .max_burst(1)) dut_b (
    .clk(clk), .reset(reset), .active(active), .empty_qu(empty_qu),
    .almost_empty_qu(almost_empty_qu), .ready(ready),
    .pop_valid(vb), .pop_sel_qu(sb), .pop_last(lb)
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, i, act, exp);
    end
  endtask

  // model: outputs from current model state and inputs, next state staged for the clock edge
  always @(negedge clk) begin : cmp
    #2;
    cyc++;
    for (int m = 0; m < 2; m++) begin : per_dut
      logic ev, el;
      logic [0:NQ-1] es;
      int q;
      bit go;
      go = active && ready && !reset;
      ev = 0; el = 0; es = '0; q = -1;
      nbusy[m] = busy[m]; ncur[m] = cur[m]; nnpop[m] = npop[m]; npr[m] = pr[m];
      if (!busy[m]) begin
        for (int k = 0; k < NQ; k++)
          if (q < 0 && !empty_qu[(pr[m] + k) % NQ]) q = (pr[m] + k) % NQ;
        if (go && q >= 0) begin
          ev = 1; es[q] = 1'b1;
          el = (mb[m] == 1) || almost_empty_qu[q];
          npr[m] = (q + 1) % NQ;
          if (!el) begin nbusy[m] = 1; ncur[m] = q; nnpop[m] = 1; end
        end
      end else if (empty_qu[cur[m]]) begin
        nbusy[m] = 0;
      end else if (go) begin
        ev = 1; es[cur[m]] = 1'b1;
        el = (npop[m] + 1 == mb[m]) || almost_empty_qu[cur[m]];
        nnpop[m] = npop[m] + 1;
        if (el) nbusy[m] = 0;
      end
      chk(m ? "b_valid" : "a_valid", cyc, 32'(m ? vb : va), 32'(ev));
      chk(m ? "b_sel" : "a_sel", cyc, 32'(m ? sb : sa), 32'(es));
      chk(m ? "b_last" : "a_last", cyc, 32'(m ? lb : la), 32'(el));
    end
  end

  // model state commit
  always @(posedge clk or posedge reset) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        busy[m] <= 0; cur[m] <= 0; npop[m] <= 0; pr[m] <= 0;
      end else if (active) begin
        busy[m] <= nbusy[m]; cur[m] <= ncur[m]; npop[m] <= nnpop[m]; pr[m] <= npr[m];
      end
    end
  end

  task automatic step(input bit act, input bit rdy, input bit rst);
    @(negedge clk);
    reset = rst;
    active = act;
    ready = rdy;
    for (int q = 0; q < NQ; q++) begin
      empty_qu[q] = (cnt_q[q] == 0);
      almost_empty_qu[q] = (cnt_q[q] == 1);
    end
    #3;
    v_q.push_back(va); sel_q.push_back(sa); l_q.push_back(la);
    bsel_q.push_back(sb); bl_q.push_back(lb);
    if (va)
      for (int q = 0; q < NQ; q++)
        if (sa[q] && cnt_q[q] > 0) cnt_q[q]--;
  endtask

  task automatic setq(input int c0, input int c1, input int c2, input int c3);
    cnt_q[0] = c0; cnt_q[1] = c1; cnt_q[2] = c2; cnt_q[3] = c3;
  endtask

  task automatic clr_logs();
    v_q.delete(); sel_q.delete(); l_q.delete(); bsel_q.delete(); bl_q.delete();
  endtask

  task automatic do_reset();
    step(1, 1, 1);
    step(1, 1, 1);
    clr_logs();
  endtask

  initial begin
    setq(0, 0, 0, 0);
    do_reset();
    begin : t_reset
      setq(50, 50, 50, 50);
      step(1, 1, 0);
      step(1, 1, 0);
      step(1, 1, 1);
      chk("rst_midburst_valid", 0, 32'(v_q[2]), 32'd0);
      chk("rst_midburst_sel", 0, 32'(sel_q[2]), 32'd0);
      step(1, 1, 0);
      chk("rst_first_sel", 0, 32'(sel_q[3]), 32'h8);
    end
    begin : t_rr
      int es[5] = '{8, 4, 2, 1, 8};
      setq(50, 50, 50, 50);
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 0);
      for (int i = 0; i < 5; i++) begin
        chk("rr_sel", i, 32'(bsel_q[i]), 32'(es[i]));
        chk("rr_last", i, 32'(bl_q[i]), 32'd1);
      end
    end
    begin : t_limit
      int el[5] = '{0, 0, 0, 1, 0};
      setq(0, 0, 10, 0);
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 0);
      for (int i = 0; i < 5; i++) begin
        chk("limit_sel", i, 32'(sel_q[i]), 32'h2);
        chk("limit_last", i, 32'(l_q[i]), 32'(el[i]));
      end
    end
    begin : t_early
      int ev[3] = '{1, 1, 0};
      int el[3] = '{0, 1, 0};
      setq(0, 2, 0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 0);
      for (int i = 0; i < 3; i++) begin
        chk("early_valid", i, 32'(v_q[i]), 32'(ev[i]));
        chk("early_last", i, 32'(l_q[i]), 32'(el[i]));
      end
    end
    begin : t_bp
      int rd[7] = '{1, 1, 0, 0, 0, 1, 1};
      int el[7] = '{0, 0, 0, 0, 0, 0, 1};
      setq(10, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 7; i++) step(1, rd[i] != 0, 0);
      for (int i = 0; i < 7; i++) begin
        chk("bp_valid", i, 32'(v_q[i]), 32'(rd[i]));
        chk("bp_sel", i, 32'(sel_q[i]), rd[i] != 0 ? 32'h8 : 32'h0);
        chk("bp_last", i, 32'(l_q[i]), 32'(el[i]));
      end
    end
    begin : t_wrap
      setq(0, 0, 1, 0);
      do_reset();
      step(1, 1, 0);
      setq(1, 0, 0, 0);
      step(1, 1, 0);
      setq(5, 5, 5, 5);
      step(1, 1, 0);
      chk("wrap_q2_sel", 0, 32'(sel_q[0]), 32'h2);
      chk("wrap_q0_sel", 1, 32'(sel_q[1]), 32'h8);
      chk("wrap_q0_last", 1, 32'(l_q[1]), 32'd1);
      chk("wrap_next_sel", 2, 32'(sel_q[2]), 32'h4);
    end
    for (int n = 0; n < 3000; n++) begin
      for (int q = 0; q < NQ; q++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) cnt_q[q] = 0;
        else if (r < 3 && cnt_q[q] < 6) cnt_q[q]++;
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
      if (v_q.size() > 64) clr_logs();
    end
    step(1, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/c_samq_pop_sched.md
C_SAMQ_POP_SCHED -- requirements
Module: c_samq_pop_sched

Interface
REQ-001 SHALL have parameter num_queues, default 4: number of queues in the statically allocated multi-queue.
REQ-002 SHALL have parameter max_burst, default 4, legal range 1..16: maximum consecutive pops from one queue before rotation.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port active, input, 1: clock enable; state updates only when high.
REQ-006 SHALL have port empty_qu, input, [0:num_queues-1]: per-queue empty flag from the queue tracker.
REQ-007 SHALL have port almost_empty_qu, input, [0:num_queues-1]: per-queue exactly-one-entry flag from the queue tracker.
REQ-008 SHALL have port ready, input, 1: downstream accepts one entry this cycle.
REQ-009 SHALL have port pop_valid, output, 1: pop one entry this cycle.
REQ-010 SHALL have port pop_sel_qu, output, [0:num_queues-1]: one-hot queue being popped; all zero when pop_valid is low.
REQ-011 SHALL have port pop_last, output, 1: current pop ends the burst.

Function
REQ-012 SHALL hold state: fsm (IDLE, BURST), one-hot cur_qu, burst counter cnt of clog2(max_burst+1) bits, one-hot round-robin pointer prio_qu.
REQ-013 SHALL generate pop_valid, pop_sel_qu and pop_last combinationally from current state and inputs (zero-cycle latency); pop_valid SHALL be zero whenever active or ready is low.
REQ-014 SHALL, in IDLE with ready and active high and any ~empty_qu bit set, pop the first non-empty queue at or after prio_qu in cyclic order (index 0 follows num_queues-1).
REQ-015 SHALL, on an IDLE pop of queue q, set prio_qu to q+1 modulo num_queues.
REQ-016 SHALL, on an IDLE pop of queue q, assert pop_last and stay in IDLE if max_burst==1 or almost_empty_qu[q]; otherwise it SHALL enter BURST with cur_qu=q and cnt=1.
REQ-017 SHALL, in BURST with ready and active high and empty_qu[cur] low, pop cur_qu and increment cnt.
REQ-018 SHALL, on that BURST pop, assert pop_last and return to IDLE when cnt+1==max_burst or almost_empty_qu[cur] is high.
REQ-019 SHALL, in BURST with empty_qu[cur] high, issue no pop and return to IDLE next cycle, leaving prio_qu unchanged.
REQ-020 SHALL, in BURST with ready low, hold all state and issue no pop, with no timeout.
REQ-021 SHALL leave prio_qu unchanged by BURST pops; fairness is per burst start.
REQ-022 SHALL never assert pop_valid for a queue whose empty_qu bit is high in that cycle.
REQ-023 SHALL let new pushes extend a burst: almost_empty_qu is sampled each cycle, not latched.

Reset
REQ-024 SHALL, on reset assertion, asynchronously set fsm=IDLE, cur_qu=0, cnt=0 and prio_qu=one-hot index 0.
REQ-025 SHALL, under reset, drive pop_valid=0, pop_sel_qu=0 and pop_last=0.
REQ-026 SHALL abandon an in-progress burst on mid-burst reset, with no pop in the reset cycle.

Structure
REQ-027 SHALL take fsm state encodings from the shared constants file; clog2 SHALL come from the shared functions file.
REQ-028 SHALL implement cyclic priority selection in a sub-module c_rr_select (inputs req, prio; output one-hot gnt), instanced once.
REQ-029 SHALL be pure RTL with no embedded tracker; it connects to the existing multi-queue tracker's pop_valid, pop_sel_qu, empty_qu and almost_empty_qu.

Verification
REQ-030 SHALL test reset: assert reset mid-burst -> pop_valid=0 immediately; after release, first pop selects queue 0 when all queues are non-empty.
REQ-031 SHALL test round-robin: num_queues=4, max_burst=1, all non-empty, ready=1 -> pop_sel_qu sequence 1000,0100,0010,0001,1000 with pop_last=1 every cycle.
REQ-032 SHALL test burst limit: max_burst=4, queue 2 holds 10 entries, others empty -> four pops of 0010 with pop_last on the 4th, then a new burst on queue 2.
REQ-033 SHALL test early burst end: queue 1 holds 2 entries, max_burst=4 -> two pops, pop_last on the 2nd, IDLE next cycle.
REQ-034 SHALL test backpressure: ready=0 for 3 cycles mid-burst -> pop_valid=0, cnt and cur_qu unchanged, burst resumes when ready=1.
REQ-035 SHALL test wrap and skip: prio at queue 3, only queue 0 non-empty -> pop 1000, prio_qu becomes 0100.
